// File: rtl/writeback.sv
// Write-back stage: tracks issued instructions through the DSP execute
// latency, retires them to the register file / status register, and
// reports read-after-write hazards and the number of pending writes.
module writeback #(
   parameter int unsigned EX_LAT = 3,
   parameter int unsigned AW     = 5
) (
   input  logic          clk,
   input  logic          rst,

   // decode-stage instruction
   input  logic          issue_i,
   input  logic          regfile_we_w_i,
   input  logic          regfile_we_uhw_i,
   input  logic [AW-1:0] addr_rd_i,
   input  logic          sr_we_i,
   input  logic [2:0]    condcode_i,
   input  logic          dm_re_i,

   // execute results
   input  logic [47:0]   p_i,
   input  logic [31:0]   dm_dout_i,

   // branch resolution
   input  logic          flush_i,

   // hazard query from decode
   input  logic [AW-1:0] addr_ra_i,
   input  logic [AW-1:0] addr_rb_i,
   input  logic [AW-1:0] addr_rc_i,

   // write-back outputs
   output logic          regfile_we_w_o,
   output logic          regfile_we_uhw_o,
   output logic [AW-1:0] addr_rd_o,
   output logic [31:0]   data_rd_o,
   output logic          sr_we_o,
   output logic [2:0]    condcode_o,
   output logic [47:0]   p_o,

   output logic          hazard_o,
   output logic [2:0]    inflight_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned PW = 48;
   localparam int unsigned CW = 3;
   localparam int unsigned IW = 3;

   typedef struct packed {
      logic          valid;
      logic          we_w;
      logic          we_uhw;
      logic [AW-1:0] addr_rd;
      logic          sr_we;
      logic [CW-1:0] condcode;
      logic          dm_re;
   } slot_t;

   slot_t         slot_q [1:EX_LAT];
   slot_t         slot_d [1:EX_LAT];
   slot_t         ret;

   logic [IW-1:0] inflight_q, inflight_d;

   logic          we_w_q,     we_w_d;
   logic          we_uhw_q,   we_uhw_d;
   logic          sr_we_q,    sr_we_d;
   logic [AW-1:0] addr_rd_q,  addr_rd_d;
   logic [CW-1:0] condcode_q, condcode_d;
   logic [DW-1:0] data_rd_q,  data_rd_d;
   logic [PW-1:0] p_q,        p_d;

   // True when a destination address matches any decode source operand
   function automatic logic src_match(input logic [AW-1:0] rd,
                                      input logic [AW-1:0] ra,
                                      input logic [AW-1:0] rb,
                                      input logic [AW-1:0] rc);
      return (rd == ra) || (rd == rb) || (rd == rc);
   endfunction

   // Slot pipeline advance; flush kills everything younger than the branch
   always_comb begin
      slot_d[1].valid    = issue_i & ~flush_i;
      slot_d[1].we_w     = regfile_we_w_i;
      slot_d[1].we_uhw   = regfile_we_uhw_i;
      slot_d[1].addr_rd  = addr_rd_i;
      slot_d[1].sr_we    = sr_we_i;
      slot_d[1].condcode = condcode_i;
      slot_d[1].dm_re    = dm_re_i;
      for (int unsigned k = 2; k <= EX_LAT; k++) begin
         slot_d[k] = slot_q[k-1];
         // the instruction entering the last slot is the branch itself
         if (flush_i && (k < EX_LAT)) begin
            slot_d[k].valid = 1'b0;
         end
      end
   end

   // Pending-write count taken from the post-edge slot contents
   always_comb begin
      inflight_d = '0;
      for (int unsigned k = 1; k <= EX_LAT; k++) begin
         inflight_d = inflight_d +
                      IW'(slot_d[k].valid & (slot_d[k].we_w | slot_d[k].we_uhw));
      end
   end

   // Retire the oldest slot; result source chosen by load flag
   always_comb begin
      ret        = slot_q[EX_LAT];
      we_w_d     = ret.valid & ret.we_w;
      we_uhw_d   = ret.valid & ret.we_uhw;
      sr_we_d    = ret.valid & ret.sr_we;
      addr_rd_d  = ret.addr_rd;
      condcode_d = ret.condcode;
      data_rd_d  = ret.dm_re ? dm_dout_i : p_i[DW-1:0];
      p_d        = p_i;
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 1; k <= EX_LAT; k++) begin
            slot_q[k] <= '0;
         end
         inflight_q <= '0;
         we_w_q     <= 1'b0;
         we_uhw_q   <= 1'b0;
         sr_we_q    <= 1'b0;
         addr_rd_q  <= '0;
         condcode_q <= '0;
         data_rd_q  <= '0;
         p_q        <= '0;
      end else begin
         for (int unsigned k = 1; k <= EX_LAT; k++) begin
            slot_q[k] <= slot_d[k];
         end
         inflight_q <= inflight_d;
         we_w_q     <= we_w_d;
         we_uhw_q   <= we_uhw_d;
         sr_we_q    <= sr_we_d;
         addr_rd_q  <= addr_rd_d;
         condcode_q <= condcode_d;
         data_rd_q  <= data_rd_d;
         p_q        <= p_d;
      end
   end

   // RAW hazard against every pending writer, including the output stage
   always_comb begin
      hazard_o = 1'b0;
      for (int unsigned k = 1; k <= EX_LAT; k++) begin
         if (slot_q[k].valid && (slot_q[k].we_w || slot_q[k].we_uhw) &&
             src_match(slot_q[k].addr_rd, addr_ra_i, addr_rb_i, addr_rc_i)) begin
            hazard_o = 1'b1;
         end
      end
      if ((we_w_q || we_uhw_q) &&
          src_match(addr_rd_q, addr_ra_i, addr_rb_i, addr_rc_i)) begin
         hazard_o = 1'b1;
      end
   end

   assign regfile_we_w_o   = we_w_q;
   assign regfile_we_uhw_o = we_uhw_q;
   assign sr_we_o          = sr_we_q;
   assign addr_rd_o        = addr_rd_q;
   assign condcode_o       = condcode_q;
   assign data_rd_o        = data_rd_q;
   assign p_o              = p_q;
   assign inflight_o       = inflight_q;

endmodule
